// File: rtl/i2s_tx_frame.sv
// -----------------------------------------------------------------------------
// i2s_tx_frame
//
// Master-mode I2S / TDM transmitter. A frame of CHANNELS samples is taken
// through a valid/ready handshake into a one-frame holding register. At each
// frame boundary the held frame is moved into the shift register. If nothing
// is held, a muted (all-zero) frame is sent instead and underflow pulses.
// Bits leave MSB first with the Philips one-bit delay. Each slot carries
// BITSIZE data bits followed by SLOT-BITSIZE zero bits.
//
// Core state advances on posedge sclk. sdata and lrclk are retimed on
// negedge sclk, so the codec can sample them on the following rising edge.
//
// Parameters
//   BITSIZE   sample width per channel (8..32)
//   SLOT      bit clocks per channel slot (SLOT >= BITSIZE)
//   CHANNELS  slots per frame, even, 2..8. 2 = I2S (lrclk is L/R),
//             >2 = TDM (lrclk is a one-bit frame sync).
//
// Ports
//   sclk       in   bit clock, the only clock
//   rst        in   asynchronous active-low reset
//   en         in   run enable. Low holds the frame counter at 0 and forces
//                   sdata/lrclk low. Dropping en aborts the current frame.
//   in_data    in   CHANNELS*BITSIZE frame, channel 0 in the MSBs
//   in_valid   in   in_data valid
//   in_ready   out  holding register empty (low while in reset)
//   lrclk      out  word select / frame sync
//   sdata      out  serial data
//   underflow  out  one-cycle pulse when a frame starts with nothing held
//
// Optional build macro I2S_TX_UFLOW_CNT_EN adds:
//   uflow_cnt  out  16-bit saturating count of underflow pulses. It is
//                   cleared by rst and on the edge where en rises.
// -----------------------------------------------------------------------------
module i2s_tx_frame #(
  parameter int BITSIZE  = 24,
  parameter int SLOT     = 32,
  parameter int CHANNELS = 2
) (
  input  logic                        sclk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [CHANNELS*BITSIZE-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        lrclk,
  output logic                        sdata,
  output logic                        underflow
`ifdef I2S_TX_UFLOW_CNT_EN
  ,
  output logic [15:0]                 uflow_cnt
`endif
);

  localparam int FRAME = CHANNELS * SLOT;
  localparam int DW    = CHANNELS * BITSIZE;
  localparam int CW    = $clog2(FRAME);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);
  localparam logic [CW-1:0] SLOT_IDX = CW'(SLOT);

  // Lays the channel samples out in transmit order. Frame bit j sits at
  // index FRAME-1-j, so the shift register always sends from its top bit.
  function automatic logic [FRAME-1:0] build_frame(input logic [DW-1:0] d);
    logic [FRAME-1:0] f;
    f = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      f[FRAME-1-c*SLOT -: BITSIZE] = d[DW-1-c*BITSIZE -: BITSIZE];
    end
    return f;
  endfunction

  logic [CW-1:0]    r_bitcnt;
  logic             r_run;
  logic [DW-1:0]    r_hold;
  logic             r_hold_full;
  logic [FRAME-1:0] r_shift;
  logic             r_bit;
  logic             r_uflow;
  logic             r_sdata;
  logic             r_lrclk;

  logic             w_start;
  logic             w_accept;
  logic             w_lr;
  logic [FRAME-1:0] w_frame;

  // A frame starts on the first enabled edge after idle, or on the wrap.
  assign w_start  = en && (!r_run || (r_bitcnt == LAST_IDX));
  assign in_ready = rst && !r_hold_full;
  assign w_accept = in_valid && in_ready;
  assign w_frame  = build_frame(r_hold);

  always_comb begin
    w_lr = 1'b0;
    if (r_run) begin
      if (CHANNELS == 2) w_lr = (r_bitcnt >= SLOT_IDX);
      else               w_lr = (r_bitcnt == LAST_IDX);
    end
  end

  // Holding register payload: only meaningful while r_hold_full is set.
  always_ff @(posedge sclk) begin
    if (w_accept) r_hold <= in_data;
  end

  // Core frame state. r_bit takes the bit leaving the shift register. That
  // gives the one-bit Philips delay: during bit period k it holds frame
  // bit k-1. At k=0 it holds the last bit of the previous frame.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      r_bitcnt    <= '0;
      r_run       <= 1'b0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_bit       <= 1'b0;
      r_uflow     <= 1'b0;
    end else begin
      r_run <= en;
      if (!en) begin
        r_bitcnt <= '0;
        r_shift  <= '0;
        r_bit    <= 1'b0;
        r_uflow  <= 1'b0;
      end else begin
        r_bit <= r_shift[FRAME-1];
        if (w_start) begin
          r_bitcnt <= '0;
          r_shift  <= r_hold_full ? w_frame : '0;
          r_uflow  <= !r_hold_full;
        end else begin
          r_bitcnt <= r_bitcnt + CW'(1);
          r_shift  <= r_shift << 1;
          r_uflow  <= 1'b0;
        end
      end
      // Accept only happens while empty and a load only consumes while
      // full, so the two branches never compete.
      if (w_accept)                         r_hold_full <= 1'b1;
      else if (en && w_start && r_hold_full) r_hold_full <= 1'b0;
    end
  end

  // Pin retiming on the falling edge.
  always_ff @(negedge sclk or negedge rst) begin
    if (!rst) begin
      r_sdata <= 1'b0;
      r_lrclk <= 1'b0;
    end else begin
      r_sdata <= r_run && r_bit;
      r_lrclk <= w_lr;
    end
  end

  assign sdata     = r_sdata;
  assign lrclk     = r_lrclk;
  assign underflow = r_uflow;

`ifdef I2S_TX_UFLOW_CNT_EN
  logic [15:0] r_uflow_cnt;
  logic        w_en_rise;

  assign w_en_rise = en && !r_run;

  // Counts each pulse on the edge after it is raised. The pulse issued at
  // an en rise is therefore counted after the clear.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      r_uflow_cnt <= '0;
    end else if (w_en_rise) begin
      r_uflow_cnt <= '0;
    end else if (r_uflow && (r_uflow_cnt != 16'hFFFF)) begin
      r_uflow_cnt <= r_uflow_cnt + 16'd1;
    end
  end

  assign uflow_cnt = r_uflow_cnt;
`endif

endmodule

// File: tb/tb_i2s_tx_frame.sv
// -----------------------------------------------------------------------------
// Testbench for i2s_tx_frame.
//
// dut_a uses the default I2S configuration (2 x 24 bits in 32-bit slots).
// A frame-level reference model follows it. The model keeps a holding flag,
// the frame being sent and its bit position. Expected pins are derived
// arithmetically from slot/offset.
//
// dut_b is a TDM configuration (4 x 16 bits in 16-bit slots). It is checked
// against fixed expected words.
// -----------------------------------------------------------------------------
module tb_i2s_tx_frame;

  localparam int CHA = 2, SLA = 32, BSA = 24, FRA = CHA * SLA;
  localparam int CHB = 4, SLB = 16, BSB = 16, FRB = CHB * SLB;

  logic sclk = 1'b0;
  logic rst;

  logic                 en_a, valid_a, rdy_a, lr_a, sd_a, uf_a;
  logic [CHA*BSA-1:0]   data_a;
  logic                 en_b, valid_b, rdy_b, lr_b, sd_b, uf_b;
  logic [CHB*BSB-1:0]   data_b;
`ifdef I2S_TX_UFLOW_CNT_EN
  logic [15:0]          ucnt_a, ucnt_b;
`endif

  always #5 sclk = ~sclk;

  i2s_tx_frame #(.BITSIZE(BSA), .SLOT(SLA), .CHANNELS(CHA)) dut_a (
    .sclk(sclk), .rst(rst), .en(en_a), .in_data(data_a), .in_valid(valid_a),
    .in_ready(rdy_a), .lrclk(lr_a), .sdata(sd_a), .underflow(uf_a)
`ifdef I2S_TX_UFLOW_CNT_EN
    , .uflow_cnt(ucnt_a)
`endif
  );

  i2s_tx_frame #(.BITSIZE(BSB), .SLOT(SLB), .CHANNELS(CHB)) dut_b (
    .sclk(sclk), .rst(rst), .en(en_b), .in_data(data_b), .in_valid(valid_b),
    .in_ready(rdy_b), .lrclk(lr_b), .sdata(sd_b), .underflow(uf_b)
`ifdef I2S_TX_UFLOW_CNT_EN
    , .uflow_cnt(ucnt_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model for dut_a ----------------
  logic               m_run, m_hold_full, m_uflow, m_last;
  int                 m_k;
  int                 m_acc = 0;
  logic [CHA*BSA-1:0] m_hold, m_cur;

  // Frame bit j of a frame: slot j/sl, offset j%sl; data if offset < bs.
  function automatic logic fbit(input logic [255:0] f, input int ch,
                                input int bs, input int sl, input int j);
    int s, o;
    s = j / sl;
    o = j % sl;
    if (o >= bs) return 1'b0;
    return f[(ch - 1 - s) * bs + (bs - 1 - o)];
  endfunction

  always @(posedge sclk or negedge rst) begin
    logic acc;
    if (!rst) begin
      m_run = 0; m_hold_full = 0; m_uflow = 0; m_last = 0; m_k = 0;
      m_cur = '0; m_hold = '0;
    end else begin
      acc = valid_a && !m_hold_full;
      if (!en_a) begin
        m_run = 0; m_k = 0; m_uflow = 0; m_cur = '0; m_last = 0;
      end else if (!m_run || m_k == FRA - 1) begin
        m_last = m_run ? fbit(256'(m_cur), CHA, BSA, SLA, FRA - 1) : 1'b0;
        if (m_hold_full) begin
          m_cur = m_hold; m_hold_full = 0; m_uflow = 0;
        end else begin
          m_cur = '0; m_uflow = 1;
        end
        m_k = 0;
        m_run = 1;
      end else begin
        m_k = m_k + 1;
        m_uflow = 0;
      end
      if (acc) begin
        m_hold = data_a; m_hold_full = 1; m_acc = m_acc + 1;
      end
    end
  end

  // Expected {sdata, lrclk, underflow, in_ready} for the current bit period.
  function automatic logic [3:0] exp_a();
    logic sd, lr;
    sd = 1'b0;
    if (m_run) sd = (m_k == 0) ? m_last : fbit(256'(m_cur), CHA, BSA, SLA, m_k - 1);
    lr = m_run && (m_k >= SLA);
    return {sd, lr, m_uflow, rst && !m_hold_full};
  endfunction

  function automatic logic [CHA*BSA-1:0] rnd_a();
    return (CHA*BSA)'({$urandom(), $urandom()});
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 0; en_a = 0; valid_a = 0; data_a = '0;
    en_b = 0; valid_b = 0; data_b = '0;
    #2;
    checks++;
    if ({sd_a, lr_a, uf_a, rdy_a, sd_b, lr_b, uf_b, rdy_b} !== 8'b0) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", {sd_a, lr_a, uf_a, rdy_a, sd_b, lr_b, uf_b, rdy_b}, 8'b0);
    end
    @(negedge sclk); #1;
    @(negedge sclk); #1;
    rst = 1;
    #1;
    checks++;
    if ({sd_a, lr_a, uf_a, rdy_a, rdy_b} !== 5'b00011) begin
      errors++;
      $display("FAIL reset_release got=%b exp=%b", {sd_a, lr_a, uf_a, rdy_a, rdy_b}, 5'b00011);
    end
`ifdef I2S_TX_UFLOW_CNT_EN
    checks++;
    if (ucnt_a !== 16'd0) begin
      errors++; $display("FAIL reset_ucnt got=%0d exp=0", ucnt_a);
    end
`endif
  endtask

  task automatic test_i2s_frame();
    logic        cap [FRA];
    logic [23:0] w;
    int          ufs;
    data_a = {24'hA5A5A5, 24'h5A5A5A};
    valid_a = 1;
    @(negedge sclk); #1;
    checks++;
    if ({sd_a, lr_a, uf_a, rdy_a} !== exp_a()) begin
      errors++; $display("FAIL frame_accept got=%b exp=%b", {sd_a, lr_a, uf_a, rdy_a}, exp_a());
    end
    valid_a = 0;
    en_a = 1;
    ufs = 0;
    for (int i = 0; i < FRA; i++) begin
      @(negedge sclk); #1;
      checks++;
      if ({sd_a, lr_a, uf_a, rdy_a} !== exp_a()) begin
        errors++; $display("FAIL frame_stream k=%0d got=%b exp=%b", i, {sd_a, lr_a, uf_a, rdy_a}, exp_a());
      end
      cap[i] = sd_a;
      if (uf_a) ufs++;
    end
    en_a = 0;
    for (int j = 0; j < 24; j++) w[23 - j] = cap[1 + j];
    checks++;
    if (w !== 24'hA5A5A5) begin errors++; $display("FAIL frame_left got=%h exp=a5a5a5", w); end
    for (int j = 0; j < 24; j++) w[23 - j] = cap[33 + j];
    checks++;
    if (w !== 24'h5A5A5A) begin errors++; $display("FAIL frame_right got=%h exp=5a5a5a", w); end
    w = '0;
    for (int j = 25; j <= 32; j++) w[j - 25] = cap[j];
    checks++;
    if (w !== 24'h0) begin errors++; $display("FAIL frame_pad got=%h exp=0", w); end
    checks++;
    if (ufs !== 0) begin errors++; $display("FAIL frame_uflow got=%0d exp=0", ufs); end
    @(negedge sclk); #1;
    checks++;
    if ({sd_a, lr_a, uf_a, rdy_a} !== exp_a()) begin
      errors++; $display("FAIL frame_idle got=%b exp=%b", {sd_a, lr_a, uf_a, rdy_a}, exp_a());
    end
  endtask

  task automatic test_underflow();
    int ufs, ones;
    ufs = 0; ones = 0;
    valid_a = 0;
    en_a = 1;
    for (int i = 0; i < 3 * FRA; i++) begin
      @(negedge sclk); #1;
      checks++;
      if ({sd_a, lr_a, uf_a, rdy_a} !== exp_a()) begin
        errors++; $display("FAIL mute_stream i=%0d got=%b exp=%b", i, {sd_a, lr_a, uf_a, rdy_a}, exp_a());
      end
      if (uf_a) ufs++;
      if (sd_a) ones++;
    end
    checks++;
    if (ufs !== 3) begin errors++; $display("FAIL mute_pulses got=%0d exp=3", ufs); end
    checks++;
    if (ones !== 0) begin errors++; $display("FAIL mute_sdata got=%0d exp=0", ones); end
`ifdef I2S_TX_UFLOW_CNT_EN
    checks++;
    if (ucnt_a !== 16'd3) begin errors++; $display("FAIL mute_ucnt got=%0d exp=3", ucnt_a); end
`endif
    en_a = 0;
    @(negedge sclk); #1;
  endtask

  task automatic test_back_to_back();
    int rdys, ufs, acc0;
    rdys = 0; ufs = 0;
    data_a = rnd_a();
    valid_a = 1;
    @(negedge sclk); #1;
    data_a = rnd_a();
    en_a = 1;
    for (int i = 0; i < 4 * FRA; i++) begin
      acc0 = m_acc;
      @(negedge sclk); #1;
      checks++;
      if ({sd_a, lr_a, uf_a, rdy_a} !== exp_a()) begin
        errors++; $display("FAIL b2b_stream i=%0d got=%b exp=%b", i, {sd_a, lr_a, uf_a, rdy_a}, exp_a());
      end
      if (rdy_a) rdys++;
      if (uf_a) ufs++;
      if (m_acc != acc0) data_a = rnd_a();
    end
    checks++;
    if (rdys !== 4) begin errors++; $display("FAIL b2b_ready got=%0d exp=4", rdys); end
    checks++;
    if (ufs !== 0) begin errors++; $display("FAIL b2b_uflow got=%0d exp=0", ufs); end
    valid_a = 0;
    en_a = 0;
    @(negedge sclk); #1;
  endtask

  task automatic test_en_drop();
    logic [CHA*BSA-1:0] held;
    logic               cap [30];
    logic [23:0]        w;
    logic               r0;
    bit                 hit;
    hit = 0;
    held = rnd_a();
    en_a = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge sclk); #1;
      checks++;
      if ({sd_a, lr_a, uf_a, rdy_a} !== exp_a()) begin
        errors++; $display("FAIL drop_run i=%0d got=%b exp=%b", i, {sd_a, lr_a, uf_a, rdy_a}, exp_a());
      end
      if (i == 0) begin data_a = held; valid_a = 1; end
      else valid_a = 0;
      if (m_run && m_k == 40) begin en_a = 0; hit = 1; break; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL drop_timeout got=0 exp=1"); end
    for (int i = 0; i < 4; i++) begin
      @(negedge sclk); #1;
      checks++;
      if ({sd_a, lr_a, uf_a, rdy_a} !== 4'b0000) begin
        errors++; $display("FAIL drop_idle i=%0d got=%b exp=0000", i, {sd_a, lr_a, uf_a, rdy_a});
      end
    end
    en_a = 1;
    r0 = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge sclk); #1;
      checks++;
      if ({sd_a, lr_a, uf_a, rdy_a} !== exp_a()) begin
        errors++; $display("FAIL drop_resume i=%0d got=%b exp=%b", i, {sd_a, lr_a, uf_a, rdy_a}, exp_a());
      end
      cap[i] = sd_a;
      if (i == 0) r0 = rdy_a;
    end
    for (int j = 0; j < 24; j++) w[23 - j] = cap[1 + j];
    checks++;
    if (w !== held[47:24]) begin errors++; $display("FAIL drop_word got=%h exp=%h", w, held[47:24]); end
    checks++;
    if (r0 !== 1'b1) begin errors++; $display("FAIL drop_ready got=%b exp=1", r0); end
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sclk); #1;
      checks++;
      if ({sd_a, lr_a, uf_a, rdy_a} !== exp_a()) begin
        errors++; $display("FAIL rstmid_run i=%0d got=%b exp=%b", i, {sd_a, lr_a, uf_a, rdy_a}, exp_a());
      end
      valid_a = 1;
      if (!m_hold_full) data_a = rnd_a();
      if (i > 2 && m_run && m_k == 20) begin hit = 1; break; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rstmid_timeout got=0 exp=1"); end
    valid_a = 0;
    #2;
    rst = 0;
    #1;
    checks++;
    if ({sd_a, lr_a, uf_a, rdy_a} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_async got=%b exp=0000", {sd_a, lr_a, uf_a, rdy_a});
    end
    @(negedge sclk); #1;
    rst = 1;
    #1;
    checks++;
    if (rdy_a !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", rdy_a); end
    for (int i = 0; i < 4; i++) begin
      @(negedge sclk); #1;
      checks++;
      if ({sd_a, lr_a, uf_a, rdy_a} !== exp_a()) begin
        errors++; $display("FAIL rstmid_after i=%0d got=%b exp=%b", i, {sd_a, lr_a, uf_a, rdy_a}, exp_a());
      end
      if (i == 0) begin
        checks++;
        if ({sd_a, uf_a} !== 2'b01) begin
          errors++; $display("FAIL rstmid_mute got=%b exp=01", {sd_a, uf_a});
        end
      end
    end
    en_a = 0;
    @(negedge sclk); #1;
  endtask

  task automatic test_random();
    int acc0;
    for (int i = 0; i < 600; i++) begin
      acc0 = m_acc;
      @(negedge sclk); #1;
      checks++;
      if ({sd_a, lr_a, uf_a, rdy_a} !== exp_a()) begin
        errors++; $display("FAIL rand_stream i=%0d got=%b exp=%b", i, {sd_a, lr_a, uf_a, rdy_a}, exp_a());
      end
      if (m_acc != acc0 || !valid_a) data_a = rnd_a();
      valid_a = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 149) == 0) en_a = !en_a;
      if (i == 0) en_a = 1;
    end
    en_a = 0;
    valid_a = 0;
    @(negedge sclk); #1;
  endtask

  task automatic test_tdm();
    logic        cap [FRB + 1];
    logic [15:0] w;
    logic [15:0] expw [4];
    int          lrs;
    expw[0] = 16'h8001; expw[1] = 16'h4002; expw[2] = 16'h2004; expw[3] = 16'h1008;
    data_b = {16'h8001, 16'h4002, 16'h2004, 16'h1008};
    valid_b = 1;
    @(negedge sclk); #1;
    valid_b = 0;
    en_b = 1;
    lrs = 0;
    for (int i = 0; i <= FRB; i++) begin
      @(negedge sclk); #1;
      cap[i] = sd_b;
      if (i < FRB && lr_b) lrs++;
      if (i == FRB - 1) begin
        checks++;
        if (lr_b !== 1'b1) begin errors++; $display("FAIL tdm_sync got=%b exp=1", lr_b); end
      end
    end
    en_b = 0;
    checks++;
    if (lrs !== 1) begin errors++; $display("FAIL tdm_sync_count got=%0d exp=1", lrs); end
    checks++;
    if (cap[0] !== 1'b0) begin errors++; $display("FAIL tdm_k0 got=%b exp=0", cap[0]); end
    for (int s = 0; s < 4; s++) begin
      for (int j = 0; j < 16; j++) w[15 - j] = cap[1 + s * SLB + j];
      checks++;
      if (w !== expw[s]) begin errors++; $display("FAIL tdm_slot%0d got=%h exp=%h", s, w, expw[s]); end
    end
    @(negedge sclk); #1;
  endtask

  initial begin
    test_reset();
    test_i2s_frame();
    test_underflow();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    test_tdm();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx_frame.md
Name: i2s_tx_frame

Overview:
- Parametrised successor to the team's fixed 2x24-bit I2S serializer.
- Master-mode I2S/TDM transmitter: generates its own word-select (lrclk) from the bit clock.
- Serializes CHANNELS samples per frame, Philips one-bit delay, MSB first.
- Takes samples through a valid/ready handshake into a one-frame holding register; sits between the audio datapath and the codec DAC pins.

Parameters:
- BITSIZE, 24: sample width per channel, 8..32.
- SLOT, 32: bit clocks per channel slot; must satisfy SLOT >= BITSIZE.
- CHANNELS, 2: slots per frame; even, 2..8. CHANNELS=2 gives I2S mode; CHANNELS>2 gives TDM mode.

Ports:
- sclk  in  1  bit clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  run enable.
- in_data  in  CHANNELS*BITSIZE  frame samples; channel 0 in the MSBs.
- in_valid  in  1  in_data valid.
- in_ready  out  1  holding register can accept a frame.
- lrclk  out  1  word select / frame sync.
- sdata  out  1  serial data.
- underflow  out  1  one-cycle pulse when a frame starts with no data held.

Behaviour:
- Clocking:
  - All core state is updated on posedge sclk.
  - sdata and lrclk are retimed on negedge sclk, so the codec samples them on the next rising edge.
  - rst=0 asynchronously clears all state.
- Reset values: bitcnt=0, hold_full=0, shift register=0, in_ready=0 while rst=0, sdata=0, lrclk=0, underflow=0.
- Frame counter:
  - bitcnt counts 0..FRAME-1, where FRAME = CHANNELS*SLOT, then wraps to 0.
  - When en=0, bitcnt is held at 0, sdata=0 and lrclk=0.
  - Raising en starts a frame with bitcnt=0.
  - Dropping en mid-frame aborts the frame immediately: bitcnt returns to 0 and the shift contents are discarded. hold_full is kept.
- Handshake:
  - in_ready = !hold_full.
  - A transfer occurs when in_valid && in_ready on a posedge; in_data is captured into the holding register and hold_full is set.
  - in_data is not sampled otherwise.
- Frame load:
  - At the posedge where bitcnt wraps to 0 (or en first rises): if hold_full, the shift register is loaded from the holding register and hold_full is cleared.
  - Otherwise the shift register is loaded with all zeros (mute frame) and underflow pulses for exactly one cycle.
  - A transfer accepted on the same edge as an empty load is kept for the next frame.
  - A full holding register has in_ready=0, so load and accept never conflict.
- Slot format: each slot carries BITSIZE bits MSB first, followed by SLOT-BITSIZE zero bits.
- Timing (Philips delay):
  - During bit period k, sdata carries frame bit k-1.
  - At k=0, sdata carries the last bit of the previous frame; this is 0 after reset, after an en rise, or after a mute frame.
- lrclk:
  - CHANNELS=2: lrclk = 0 for k in [0, SLOT) (left) and 1 for k in [SLOT, 2*SLOT) (right).
  - CHANNELS>2: lrclk = 1 only during k = FRAME-1, a one-bit sync preceding slot 0's MSB.
- Latency: a sample accepted while the holding register is empty is transmitted starting at the next frame boundary; throughput is one frame per FRAME sclk cycles.

Optional Feature:
- Macro I2S_TX_UFLOW_CNT_EN.
- When defined: adds output uflow_cnt[15:0].
  - Increments on every underflow pulse and saturates at 16'hFFFF.
  - Cleared by rst.
  - Also cleared on the posedge where en rises.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Defaults, en=1, one frame with left=24'hA5A5A5, right=24'h5A5A5A provided before the first boundary -> lrclk low for 32 bits then high for 32; sdata bits 1..24 = A5A5A5 MSB first, bits 25..32 = 0; bits 33..56 = 5A5A5A; underflow never pulses.
- en=1 with in_valid=0 for 3 frames -> three mute frames with sdata=0 throughout, underflow pulses at each wrap (3 pulses, each 1 cycle wide); with I2S_TX_UFLOW_CNT_EN, uflow_cnt=3.
- in_valid held high continuously -> in_ready low except one cycle per frame; no underflow; consecutive frames carry consecutive sample words with no gaps.
- CHANNELS=4, SLOT=16, BITSIZE=16, data 16'h8001 / 16'h4002 / 16'h2004 / 16'h1008 -> lrclk high only at bitcnt=63; sdata shows 8001, 4002, 2004, 1008 starting one bit after the sync.
- rst asserted low at bitcnt=20 mid-frame -> sdata, lrclk and underflow go 0 asynchronously and in_ready goes 0; after release in_ready=1 and the next frame starts at bitcnt=0 with a mute frame.
- en dropped at bitcnt=40 with a held frame -> sdata=0 and lrclk=0 while en=0; on en rise the held frame is transmitted starting at k=1, in_ready=1 after the load.
